// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM encoding,
// key codes, the physical layout table and the decimal-entry helper.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_DB,
    ST_HELD,
    ST_RELEASE_DB
  } kp_state_e;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Indexed by row*4 + col.
  localparam logic [15:0][3:0] KEY_LAYOUT = {
    KEY_D, KEY_HASH, 4'd0, KEY_STAR,
    KEY_C, 4'd9,     4'd8, 4'd7,
    KEY_B, 4'd6,     4'd5, 4'd4,
    KEY_A, 4'd3,     4'd2, 4'd1
  };

  // entry < 10000 always, so (entry*10 + d) mod 10000 == (entry mod 1000)*10 + d.
  function automatic logic [31:0] entry_shift(input logic [31:0] cur, input logic [3:0] digit);
    return ((cur % 32'd1000) * 32'd10) + {28'd0, digit};
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Column scanner, row synchronizer and per-scan press/release debouncer.
// Emits a one-cycle key_valid with the accepted key code.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clk_1khz,
  input  logic       rst,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int unsigned SLOT_W   = $clog2(SLOT_CYCLES);
  localparam int unsigned CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic        ONE_SCAN = (DEBOUNCE_SCANS <= 1);

  logic [3:0]        sync1_q, sync2_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        col_q, col_d;
  logic [15:0]       map_q, map_d, scan_map;
  kp_state_e         state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [3:0]        code_q, code_d;

  logic              slot_last, scan_done;
  logic [4:0]        n_pressed;
  logic [3:0]        hit_idx;
  logic              single, none;
  logic [31:0]       cnt_inc;
  logic              cnt_done;

  always_comb begin
    slot_last = (slot_q == SLOT_W'(SLOT_CYCLES - 1));
    scan_done = slot_last && (col_q == 2'd3);
    slot_d    = slot_last ? '0 : slot_q + 1'b1;
    col_d     = slot_last ? col_q + 2'd1 : col_q;

    // Merge this slot's rows into the map so the final column is visible on scan_done.
    scan_map = map_q;
    for (int unsigned r = 0; r < 4; r++) begin
      scan_map[{2'(r), col_q}] = ~sync2_q[r];
    end
    map_d = scan_done ? '0 : (slot_last ? scan_map : map_q);

    n_pressed = '0;
    hit_idx   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (scan_map[i]) begin
        n_pressed = n_pressed + 5'd1;
        hit_idx   = 4'(i);
      end
    end
    single   = (n_pressed == 5'd1);
    none     = (n_pressed == 5'd0);
    cnt_inc  = 32'(cnt_q) + 32'd1;
    cnt_done = (cnt_inc >= DEBOUNCE_SCANS);
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    code_d  = code_q;
    if (scan_done) begin
      unique case (state_q)
        ST_IDLE: begin
          if (single) begin
            cand_d = hit_idx;
            cnt_d  = CNT_W'(1);
            if (ONE_SCAN) begin
              state_d = ST_HELD;
              valid_d = 1'b1;
              code_d  = KEY_LAYOUT[hit_idx];
            end else begin
              state_d = ST_PRESS_DB;
            end
          end
        end
        ST_PRESS_DB: begin
          if (single && (hit_idx == cand_q)) begin
            cnt_d = CNT_W'(cnt_inc);
            if (cnt_done) begin
              state_d = ST_HELD;
              valid_d = 1'b1;
              code_d  = KEY_LAYOUT[cand_q];
            end
          end else if (single) begin
            cand_d = hit_idx;
            cnt_d  = CNT_W'(1);
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (none) begin
            cnt_d   = ONE_SCAN ? '0 : CNT_W'(1);
            state_d = ONE_SCAN ? ST_IDLE : ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          if (none) begin
            cnt_d = CNT_W'(cnt_inc);
            if (cnt_done) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      slot_q  <= '0;
      col_q   <= '0;
      map_q   <= '0;
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      sync1_q <= rows_n;
      sync2_q <= sync1_q;
      slot_q  <= slot_d;
      col_q   <= col_d;
      map_q   <= map_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  assign cols_n    = ~(4'b0001 << col_q);
  assign key_valid = valid_q;
  assign key_code  = code_q;

endmodule

// File: rtl/keypad_scan.sv
// Keypad front end plus decimal accumulator: digits shift into a 4-digit
// entry, '*' clears it, '#' commits it to value_out.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SLOT_CYCLES    = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic        clk_1khz,
  input  logic        rst,
  input  logic [3:0]  rows_n,
  output logic [3:0]  cols_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] entry,
  output logic [31:0] value_out,
  output logic        commit
);

  logic [31:0] entry_q, entry_d;
  logic [31:0] value_q, value_d;
  logic        commit_d;

  keypad_debounce #(
    .SLOT_CYCLES    (SLOT_CYCLES),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clk_1khz  (clk_1khz),
    .rst       (rst),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key_valid (key_valid),
    .key_code  (key_code)
  );

  always_comb begin
    entry_d  = entry_q;
    value_d  = value_q;
    commit_d = 1'b0;
    if (key_valid) begin
      if (key_code <= 4'd9) begin
        entry_d = entry_shift(entry_q, key_code);
      end else if (key_code == KEY_STAR) begin
        entry_d = '0;
      end else if (key_code == KEY_HASH) begin
        value_d  = entry_q;
        commit_d = 1'b1;
        entry_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      entry_q <= '0;
      value_q <= '0;
    end else begin
      entry_q <= entry_d;
      value_q <= value_d;
    end
  end

  // Outputs follow the next-state values so the update is visible in the key_valid cycle.
  assign entry     = entry_d;
  assign value_out = value_d;
  assign commit    = commit_d;

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model answers the column drive,
// expected accepts are queued at stimulus time and popped on key_valid.
module tb_keypad_scan;

  localparam int unsigned SLOT = 4;
  localparam int unsigned SCAN = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rows_n;
  logic [3:0]  cols_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] entry;
  logic [31:0] value_out;
  logic        commit;

  logic [15:0] held_keys;
  logic        started;

  typedef struct {
    logic [3:0]  code;
    logic [31:0] entry;
    logic [31:0] value;
    logic        commit;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_entry  = 0;
  int unsigned m_value  = 0;

  // Key code -> row*4+col position on the pad.
  int unsigned code_pos [16] = '{13, 0, 1, 2, 4, 5, 6, 8, 9, 10, 3, 7, 11, 15, 12, 14};

  always #5 clk = ~clk;

  keypad_scan #(
    .SLOT_CYCLES    (SLOT),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk_1khz  (clk),
    .rst       (rst),
    .rows_n    (rows_n),
    .cols_n    (cols_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .entry     (entry),
    .value_out (value_out),
    .commit    (commit)
  );

  always_comb begin
    rows_n = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!cols_n[c] && held_keys[r*4 + c]) rows_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic expect_key(input int unsigned code);
    exp_t e;
    logic c;
    c = 1'b0;
    if (code <= 9) begin
      m_entry = (m_entry * 10 + code) % 10000;
    end else if (code == 14) begin
      m_entry = 0;
    end else if (code == 15) begin
      m_value = m_entry;
      m_entry = 0;
      c = 1'b1;
    end
    e.code   = 4'(code);
    e.entry  = m_entry;
    e.value  = m_value;
    e.commit = c;
    sb.push_back(e);
  endtask

  task automatic align_scan();
    logic [3:0] prev;
    bit found;
    found = 0;
    prev  = cols_n;
    for (int i = 0; i < 80 && !found; i++) begin
      @(posedge clk);
      #1;
      if (cols_n == 4'b1110 && prev != 4'b1110) found = 1;
      prev = cols_n;
    end
    if (!found) check("align_timeout", 1, 0);
  endtask

  task automatic hold(input logic [15:0] keys, input int unsigned scans);
    held_keys = keys;
    repeat (scans * SCAN) @(posedge clk);
    #1;
  endtask

  task automatic tap(input int unsigned code, input int unsigned scans);
    expect_key(code);
    hold(16'd1 << code_pos[code], scans);
    hold('0, 5);
    check("entry_hold", entry, m_entry);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cols"}, {28'd0, cols_n}, 32'hE);
    check({tag, "_valid"}, {31'd0, key_valid}, 0);
    check({tag, "_code"}, {28'd0, key_code}, 0);
    check({tag, "_entry"}, entry, 0);
    check({tag, "_value"}, value_out, 0);
    check({tag, "_commit"}, {31'd0, commit}, 0);
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      check("cols_onehot", $countones(~cols_n), 1);
      if (key_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_key_valid", {28'd0, key_code}, 32'hFFFF);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("key_code", {28'd0, key_code}, {28'd0, e.code});
          check("entry", entry, e.entry);
          check("value_out", value_out, e.value);
          check("commit", {31'd0, commit}, {31'd0, e.commit});
        end
      end else begin
        check("commit_without_key", {31'd0, commit}, 0);
      end
    end
  end

  initial begin
    started   = 1'b0;
    rst       = 1'b1;
    held_keys = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst     = 1'b0;
    started = 1'b1;

    align_scan();
    tap(5, 6);
    check("entry_after_5", entry, 5);

    tap(1, 5); tap(2, 5); tap(3, 5); tap(4, 5);
    check("entry_1234", entry, 1234);
    tap(15, 5);
    check("value_1234", value_out, 1234);
    check("entry_cleared", entry, 0);

    tap(9, 5); tap(8, 5); tap(7, 5); tap(6, 5); tap(5, 5);
    check("entry_8765", entry, 8765);

    tap(10, 5);
    tap(13, 5);
    check("entry_after_letters", entry, 8765);
    tap(14, 5);
    check("entry_after_star", entry, 0);
    tap(0, 5);
    tap(15, 5);
    check("value_zero_commit", value_out, 0);

    // Bounce then stable 7; only the stable run may be accepted.
    hold(16'd1 << code_pos[7], 1);
    hold('0, 1);
    expect_key(7);
    hold(16'd1 << code_pos[7], 5);
    hold('0, 5);

    // Two-scan glitch alone: no accept.
    hold(16'd1 << code_pos[7], 2);
    hold('0, 5);

    // Two keys together, then release '2'.
    hold((16'd1 << code_pos[1]) | (16'd1 << code_pos[2]), 5);
    expect_key(1);
    hold(16'd1 << code_pos[1], 5);
    hold('0, 5);
    check("entry_71", entry, 71);

    // Reset while '3' is held; re-acceptance needs a full debounce.
    expect_key(3);
    hold(16'd1 << code_pos[3], 5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midhold_reset");
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_entry = 0;
    m_value = 0;
    repeat (2 * SCAN) @(posedge clk);
    expect_key(3);
    repeat (3 * SCAN) @(posedge clk);
    #1;
    hold('0, 5);
    check("entry_after_reset_3", entry, 3);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
